// File: rtl/mem_lsu_ysyx_23060136.sv
// ---------------------------------------------------------------------------
// mem_lsu_ysyx_23060136 -- memory stage / load-store unit
//
// Accepts one EXU result at a time over a valid/ready handshake. Non-memory
// results and misaligned accesses go straight to the write-back register.
// Aligned loads and stores run a request/response exchange with the memory
// port, then produce a write-back result.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   MEM_i_* / MEM_o_ready  upstream handshake and captured instruction fields
//   LSU_o_* / LSU_i_*      memory request (addr/wen/wdata/wstrb) and response
//   MEM_o_* / MEM_i_ready  registered write-back result and its handshake
// ---------------------------------------------------------------------------
module mem_lsu_ysyx_23060136 (
    input  logic        clk,
    input  logic        rst,

    // Upstream (EXU) handshake and payload
    input  logic        MEM_i_valid,
    output logic        MEM_o_ready,
    input  logic [31:0] MEM_i_pc,
    input  logic [31:0] MEM_i_inst,
    input  logic [31:0] MEM_i_ALUout,
    input  logic [31:0] MEM_i_CSR_out,
    input  logic [31:0] MEM_i_rs2_data,
    input  logic [4:0]  MEM_i_rd,
    input  logic [2:0]  MEM_i_csr_rd,
    input  logic [3:0]  MEM_i_ctrl,
    input  logic [4:0]  MEM_i_size,
    input  logic        MEM_i_system_halt,

    // Memory port
    output logic        LSU_o_req_valid,
    input  logic        LSU_i_req_ready,
    output logic [31:0] LSU_o_addr,
    output logic        LSU_o_wen,
    output logic [31:0] LSU_o_wdata,
    output logic [3:0]  LSU_o_wstrb,
    input  logic        LSU_i_resp_valid,
    input  logic [31:0] LSU_i_rdata,

    // Downstream (WB) handshake and payload
    output logic        MEM_o_valid,
    input  logic        MEM_i_ready,
    output logic [31:0] MEM_o_pc,
    output logic [31:0] MEM_o_inst,
    output logic [4:0]  MEM_o_rd,
    output logic [2:0]  MEM_o_csr_rd,
    output logic [1:0]  MEM_o_wr,
    output logic [31:0] MEM_o_wb_data,
    output logic [31:0] MEM_o_CSR_out,
    output logic        MEM_o_system_halt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // -----------------------------------------------------------------------
    // Input decode
    // -----------------------------------------------------------------------
    logic       write_gpr_in;
    logic       write_csr_in;
    logic       mem_to_reg_in;
    logic       write_mem_in;
    logic [1:0] off_in;
    logic       is_byte_in;
    logic       is_half_in;
    logic       is_word_in;
    logic       is_mem_in;
    logic       misaligned_in;

    assign {write_gpr_in, write_csr_in, mem_to_reg_in, write_mem_in} = MEM_i_ctrl;
    assign off_in     = MEM_i_ALUout[1:0];

    // Size is one-hot {half_u, byte_u, word, half, byte}; signedness only
    // matters for load extension, so width classes merge both flavours.
    assign is_byte_in = MEM_i_size[0] | MEM_i_size[3];
    assign is_half_in = MEM_i_size[1] | MEM_i_size[4];
    assign is_word_in = MEM_i_size[2];
    assign is_mem_in  = mem_to_reg_in | write_mem_in;

    assign misaligned_in = is_mem_in &&
                           ((is_half_in && off_in[0]) ||
                            (is_word_in && (off_in != 2'b00)));

    // -----------------------------------------------------------------------
    // Handshake qualifiers
    // -----------------------------------------------------------------------
    logic accept;
    logic start_req;
    logic direct_wb;
    logic resp_done;

    // Only take a new op when idle and the write-back slot is free or
    // draining this cycle; held low throughout reset.
    assign MEM_o_ready = !rst && (state == IDLE) && (!MEM_o_valid || MEM_i_ready);
    assign accept      = MEM_i_valid && MEM_o_ready;
    assign start_req   = accept && is_mem_in && !misaligned_in;
    // Non-memory ops and misaligned accesses bypass the memory port.
    assign direct_wb   = accept && !start_req;
    assign resp_done   = (state == RESP) && LSU_i_resp_valid;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (start_req)        state_next = REQ;
            REQ:     if (LSU_i_req_ready)  state_next = RESP;
            RESP:    if (LSU_i_resp_valid) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    assign LSU_o_req_valid = !rst && (state == REQ);

    // -----------------------------------------------------------------------
    // Store formatting: replicate data across lanes, strobe the target bytes
    // -----------------------------------------------------------------------
    logic [3:0]  wstrb_in;
    logic [31:0] wdata_in;

    always_comb begin
        wstrb_in = 4'b1111;
        wdata_in = MEM_i_rs2_data;
        if (is_byte_in) begin
            wstrb_in = 4'b0001 << off_in;
            wdata_in = {4{MEM_i_rs2_data[7:0]}};
        end else if (is_half_in) begin
            wstrb_in = 4'b0011 << off_in;
            wdata_in = {2{MEM_i_rs2_data[15:0]}};
        end
    end

    // -----------------------------------------------------------------------
    // Request registers: stable for the whole REQ phase
    // -----------------------------------------------------------------------
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr  <= '0;
            req_wen   <= 1'b0;
            req_wdata <= '0;
            req_wstrb <= '0;
        end else if (start_req) begin
            req_addr  <= {MEM_i_ALUout[31:2], 2'b00};
            req_wen   <= write_mem_in;
            // Loads present no write lanes.
            req_wdata <= write_mem_in ? wdata_in : '0;
            req_wstrb <= write_mem_in ? wstrb_in : 4'b0000;
        end
    end

    assign LSU_o_addr  = req_addr;
    assign LSU_o_wen   = req_wen;
    assign LSU_o_wdata = req_wdata;
    assign LSU_o_wstrb = req_wstrb;

    // -----------------------------------------------------------------------
    // Pending instruction fields, held while the memory access is in flight
    // -----------------------------------------------------------------------
    logic [31:0] p_pc;
    logic [31:0] p_inst;
    logic [31:0] p_alu;
    logic [31:0] p_csr_out;
    logic [4:0]  p_rd;
    logic [2:0]  p_csr_rd;
    logic [1:0]  p_wr;
    logic        p_mem_to_reg;
    logic        p_halt;
    logic [1:0]  p_off;
    logic        p_byte_s;
    logic        p_half_s;
    logic        p_byte_u;
    logic        p_half_u;

    // NOTE: pure datapath holding registers carry no reset; they are only
    // consumed after being loaded on an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            p_pc         <= MEM_i_pc;
            p_inst       <= MEM_i_inst;
            p_alu        <= MEM_i_ALUout;
            p_csr_out    <= MEM_i_CSR_out;
            p_rd         <= MEM_i_rd;
            p_csr_rd     <= MEM_i_csr_rd;
            p_wr         <= {write_gpr_in, write_csr_in};
            p_mem_to_reg <= mem_to_reg_in;
            p_halt       <= MEM_i_system_halt;
            p_off        <= off_in;
            p_byte_s     <= MEM_i_size[0];
            p_half_s     <= MEM_i_size[1];
            p_byte_u     <= MEM_i_size[3];
            p_half_u     <= MEM_i_size[4];
        end
    end

    // -----------------------------------------------------------------------
    // Load alignment and extension
    // -----------------------------------------------------------------------
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    assign rdata_shifted = LSU_i_rdata >> {p_off, 3'b000};

    always_comb begin
        load_data = rdata_shifted;
        if (p_byte_s) begin
            load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
        end else if (p_half_s) begin
            load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
        end else if (p_byte_u) begin
            load_data = {24'd0, rdata_shifted[7:0]};
        end else if (p_half_u) begin
            load_data = {16'd0, rdata_shifted[15:0]};
        end
    end

    // -----------------------------------------------------------------------
    // Write-back output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_o_valid       <= 1'b0;
            MEM_o_pc          <= '0;
            MEM_o_inst        <= '0;
            MEM_o_rd          <= '0;
            MEM_o_csr_rd      <= '0;
            MEM_o_wr          <= '0;
            MEM_o_wb_data     <= '0;
            MEM_o_CSR_out     <= '0;
            MEM_o_system_halt <= 1'b0;
        end else if (direct_wb) begin
            // A misaligned access turns into a halt with no register write.
            MEM_o_valid       <= 1'b1;
            MEM_o_pc          <= MEM_i_pc;
            MEM_o_inst        <= MEM_i_inst;
            MEM_o_rd          <= MEM_i_rd;
            MEM_o_csr_rd      <= MEM_i_csr_rd;
            MEM_o_wr          <= misaligned_in ? 2'b00 : {write_gpr_in, write_csr_in};
            MEM_o_wb_data     <= MEM_i_ALUout;
            MEM_o_CSR_out     <= MEM_i_CSR_out;
            MEM_o_system_halt <= misaligned_in | MEM_i_system_halt;
        end else if (resp_done) begin
            // The slot is always empty here: a memory op is only accepted
            // while the previous result drains, and it loads nothing itself.
            MEM_o_valid       <= 1'b1;
            MEM_o_pc          <= p_pc;
            MEM_o_inst        <= p_inst;
            MEM_o_rd          <= p_rd;
            MEM_o_csr_rd      <= p_csr_rd;
            MEM_o_wr          <= p_wr;
            MEM_o_wb_data     <= p_mem_to_reg ? load_data : p_alu;
            MEM_o_CSR_out     <= p_csr_out;
            MEM_o_system_halt <= p_halt;
        end else if (MEM_i_ready) begin
            MEM_o_valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_lsu_ysyx_23060136.sv
// ---------------------------------------------------------------------------
// Self-checking bench for mem_lsu_ysyx_23060136. Expected write-back results
// are queued when an op is accepted and compared when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_mem_lsu_ysyx_23060136;

    logic        clk;
    logic        rst;
    logic        MEM_i_valid;
    logic        MEM_o_ready;
    logic [31:0] MEM_i_pc;
    logic [31:0] MEM_i_inst;
    logic [31:0] MEM_i_ALUout;
    logic [31:0] MEM_i_CSR_out;
    logic [31:0] MEM_i_rs2_data;
    logic [4:0]  MEM_i_rd;
    logic [2:0]  MEM_i_csr_rd;
    logic [3:0]  MEM_i_ctrl;
    logic [4:0]  MEM_i_size;
    logic        MEM_i_system_halt;
    logic        LSU_o_req_valid;
    logic        LSU_i_req_ready;
    logic [31:0] LSU_o_addr;
    logic        LSU_o_wen;
    logic [31:0] LSU_o_wdata;
    logic [3:0]  LSU_o_wstrb;
    logic        LSU_i_resp_valid;
    logic [31:0] LSU_i_rdata;
    logic        MEM_o_valid;
    logic        MEM_i_ready;
    logic [31:0] MEM_o_pc;
    logic [31:0] MEM_o_inst;
    logic [4:0]  MEM_o_rd;
    logic [2:0]  MEM_o_csr_rd;
    logic [1:0]  MEM_o_wr;
    logic [31:0] MEM_o_wb_data;
    logic [31:0] MEM_o_CSR_out;
    logic        MEM_o_system_halt;

    mem_lsu_ysyx_23060136 dut (
        .clk               (clk),
        .rst               (rst),
        .MEM_i_valid       (MEM_i_valid),
        .MEM_o_ready       (MEM_o_ready),
        .MEM_i_pc          (MEM_i_pc),
        .MEM_i_inst        (MEM_i_inst),
        .MEM_i_ALUout      (MEM_i_ALUout),
        .MEM_i_CSR_out     (MEM_i_CSR_out),
        .MEM_i_rs2_data    (MEM_i_rs2_data),
        .MEM_i_rd          (MEM_i_rd),
        .MEM_i_csr_rd      (MEM_i_csr_rd),
        .MEM_i_ctrl        (MEM_i_ctrl),
        .MEM_i_size        (MEM_i_size),
        .MEM_i_system_halt (MEM_i_system_halt),
        .LSU_o_req_valid   (LSU_o_req_valid),
        .LSU_i_req_ready   (LSU_i_req_ready),
        .LSU_o_addr        (LSU_o_addr),
        .LSU_o_wen         (LSU_o_wen),
        .LSU_o_wdata       (LSU_o_wdata),
        .LSU_o_wstrb       (LSU_o_wstrb),
        .LSU_i_resp_valid  (LSU_i_resp_valid),
        .LSU_i_rdata       (LSU_i_rdata),
        .MEM_o_valid       (MEM_o_valid),
        .MEM_i_ready       (MEM_i_ready),
        .MEM_o_pc          (MEM_o_pc),
        .MEM_o_inst        (MEM_o_inst),
        .MEM_o_rd          (MEM_o_rd),
        .MEM_o_csr_rd      (MEM_o_csr_rd),
        .MEM_o_wr          (MEM_o_wr),
        .MEM_o_wb_data     (MEM_o_wb_data),
        .MEM_o_CSR_out     (MEM_o_CSR_out),
        .MEM_o_system_halt (MEM_o_system_halt)
    );

    // ctrl = {write_gpr, write_csr, mem_to_reg, write_mem}
    localparam logic [3:0] C_ALU   = 4'b1000;
    localparam logic [3:0] C_LOAD  = 4'b1010;
    localparam logic [3:0] C_STORE = 4'b0001;
    // size = {half_u, byte_u, word, half, byte}
    localparam logic [4:0] S_B  = 5'b00001;
    localparam logic [4:0] S_H  = 5'b00010;
    localparam logic [4:0] S_W  = 5'b00100;
    localparam logic [4:0] S_BU = 5'b01000;
    localparam logic [4:0] S_HU = 5'b10000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] csr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [2:0]  csr_rd;
        logic [3:0]  ctrl;
        logic [4:0]  size;
        logic        halt;
    } op_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  wr;
        logic [31:0] wb;
        logic [31:0] csr;
        logic        halt;
    } res_t;

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    res_t exp_q[$];
    res_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic op_t mk(input logic [31:0] pc, input logic [3:0] ctrl,
                               input logic [4:0] size, input logic [31:0] alu,
                               input logic [31:0] rs2);
        op_t o;
        o.pc = pc; o.inst = pc ^ 32'h0000_0013; o.alu = alu; o.csr = ~alu;
        o.rs2 = rs2; o.rd = pc[6:2]; o.csr_rd = pc[4:2]; o.ctrl = ctrl;
        o.size = size; o.halt = 1'b0;
        return o;
    endfunction

    // Reference model: byte/halfword picked by lane index, then extended.
    function automatic res_t model(input op_t op, input logic [31:0] rdata);
        res_t r;
        logic [1:0]  off;
        logic        mem_op;
        logic        mis;
        logic [7:0]  b;
        logic [15:0] h;
        off    = op.alu[1:0];
        mem_op = op.ctrl[1] | op.ctrl[0];
        mis    = mem_op && ((op.size[2] && off != 2'b00) ||
                            ((op.size[1] | op.size[4]) && off[0]));
        b      = rdata[8*off +: 8];
        h      = rdata[16*off[1] +: 16];
        r.pc   = op.pc;
        r.rd   = op.rd;
        r.csr  = op.csr;
        r.wr   = mis ? 2'b00 : op.ctrl[3:2];
        r.halt = mis | op.halt;
        r.wb   = op.alu;
        if (!mis && op.ctrl[1]) begin
            if (op.size[0])      r.wb = {{24{b[7]}}, b};
            else if (op.size[1]) r.wb = {{16{h[15]}}, h};
            else if (op.size[3]) r.wb = {24'd0, b};
            else if (op.size[4]) r.wb = {16'd0, h};
            else                 r.wb = rdata;
        end
        return r;
    endfunction

    // Scoreboard: every result the DUT hands off must match the queue head.
    always @(negedge clk) begin
        if (!rst && MEM_o_valid && MEM_i_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: result pc=%h with nothing expected", MEM_o_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({MEM_o_pc, MEM_o_rd, MEM_o_wr, MEM_o_wb_data, MEM_o_CSR_out, MEM_o_system_halt} !==
                    {mon_e.pc, mon_e.rd, mon_e.wr, mon_e.wb, mon_e.csr, mon_e.halt})
                    $display("FAIL sb_result: got pc=%h rd=%0d wr=%b wb=%h csr=%h halt=%b, want pc=%h rd=%0d wr=%b wb=%h csr=%h halt=%b",
                             MEM_o_pc, MEM_o_rd, MEM_o_wr, MEM_o_wb_data, MEM_o_CSR_out, MEM_o_system_halt,
                             mon_e.pc, mon_e.rd, mon_e.wr, mon_e.wb, mon_e.csr, mon_e.halt);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op until accepted (bounded); enqueue its expected result.
    task automatic issue(input op_t op, input logic [31:0] rdata, input bit push,
                         output int acc_cyc);
        bit done;
        done = 1'b0;
        acc_cyc = -1;
        MEM_i_valid = 1'b1;
        MEM_i_pc = op.pc; MEM_i_inst = op.inst; MEM_i_ALUout = op.alu;
        MEM_i_CSR_out = op.csr; MEM_i_rs2_data = op.rs2; MEM_i_rd = op.rd;
        MEM_i_csr_rd = op.csr_rd; MEM_i_ctrl = op.ctrl; MEM_i_size = op.size;
        MEM_i_system_halt = op.halt;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (MEM_o_ready === 1'b1) begin
                done = 1'b1;
                acc_cyc = cyc;
                if (push) exp_q.push_back(model(op, rdata));
            end
            @(posedge clk);
            #1;
        end
        MEM_i_valid = 1'b0;
        n_total++;
        if (!done) $display("FAIL issue_timeout: got accepted=%b, want 1 (pc=%h)", done, op.pc);
        else n_pass++;
    endtask

    // Serve the pending request: stall req_ready, then answer after resp_wait.
    task automatic mem_access(input logic [31:0] rdata, input int req_wait, input int resp_wait);
        for (int i = 0; i < req_wait; i++) tick();
        n_total++;
        if (LSU_o_req_valid !== 1'b1) $display("FAIL req_valid_present: got %b, want 1", LSU_o_req_valid);
        else n_pass++;
        LSU_i_req_ready = 1'b1;
        tick();
        LSU_i_req_ready = 1'b0;
        for (int i = 0; i < resp_wait; i++) tick();
        LSU_i_resp_valid = 1'b1;
        LSU_i_rdata = rdata;
        tick();
        LSU_i_resp_valid = 1'b0;
        LSU_i_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; MEM_i_valid = 1'b0; MEM_i_ready = 1'b1;
        LSU_i_req_ready = 1'b0; LSU_i_resp_valid = 1'b0; LSU_i_rdata = 32'h0;
        MEM_i_pc = 0; MEM_i_inst = 0; MEM_i_ALUout = 0; MEM_i_CSR_out = 0;
        MEM_i_rs2_data = 0; MEM_i_rd = 0; MEM_i_csr_rd = 0; MEM_i_ctrl = 0;
        MEM_i_size = 0; MEM_i_system_halt = 0;
        tick(); tick();
        n_total++;
        if (MEM_o_ready !== 1'b0) $display("FAIL rst_ready_low: got %b, want 0", MEM_o_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (MEM_o_ready !== 1'b1) $display("FAIL rst_ready_after: got %b, want 1", MEM_o_ready);
        else n_pass++;
        n_total++;
        if ({MEM_o_valid, LSU_o_req_valid, MEM_o_wr, MEM_o_system_halt} !== 5'b0)
            $display("FAIL rst_flags: got valid=%b req=%b wr=%b halt=%b, want all 0",
                     MEM_o_valid, LSU_o_req_valid, MEM_o_wr, MEM_o_system_halt);
        else n_pass++;
        n_total++;
        if ({MEM_o_pc, MEM_o_wb_data, LSU_o_addr, LSU_o_wstrb} !== 100'b0)
            $display("FAIL rst_data: got pc=%h wb=%h addr=%h wstrb=%b, want 0",
                     MEM_o_pc, MEM_o_wb_data, LSU_o_addr, LSU_o_wstrb);
        else n_pass++;
        tick();
    endtask

    task automatic test_alu();
        int acc;
        bit seen_req;
        seen_req = 1'b0;
        issue(mk(32'h8000_0100, C_ALU, S_W, 32'h0000_1234, 32'h0), 32'h0, 1'b1, acc);
        n_total++;
        if (MEM_o_valid !== 1'b1 || cyc - acc != 1)
            $display("FAIL alu_latency: got valid=%b after %0d cycles, want 1 after 1", MEM_o_valid, cyc - acc);
        else n_pass++;
        n_total++;
        if (MEM_o_wb_data !== 32'h0000_1234) $display("FAIL alu_wb: got %h, want 00001234", MEM_o_wb_data);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (LSU_o_req_valid !== 1'b0) seen_req = 1'b1;
            tick();
        end
        n_total++;
        if (seen_req) $display("FAIL alu_no_req: got req_valid=1, want never");
        else n_pass++;
    endtask

    task automatic test_load_byte();
        int acc;
        issue(mk(32'h8000_0200, C_LOAD, S_B, 32'h8000_0003, 32'h0), 32'h80FF_FFFF, 1'b1, acc);
        n_total++;
        if ({LSU_o_req_valid, LSU_o_addr, LSU_o_wen, LSU_o_wstrb} !== {1'b1, 32'h8000_0000, 1'b0, 4'b0000})
            $display("FAIL lb_req: got req=%b addr=%h wen=%b wstrb=%b, want 1 80000000 0 0000",
                     LSU_o_req_valid, LSU_o_addr, LSU_o_wen, LSU_o_wstrb);
        else n_pass++;
        LSU_i_req_ready = 1'b1;
        tick();
        LSU_i_req_ready = 1'b0;
        n_total++;
        if (LSU_o_req_valid !== 1'b0) $display("FAIL lb_req_drop: got %b, want 0", LSU_o_req_valid);
        else n_pass++;
        LSU_i_resp_valid = 1'b1;
        LSU_i_rdata = 32'h80FF_FFFF;
        tick();
        LSU_i_resp_valid = 1'b0;
        n_total++;
        if (MEM_o_valid !== 1'b1 || cyc - acc != 3)
            $display("FAIL lb_latency: got valid=%b after %0d cycles, want 1 after 3", MEM_o_valid, cyc - acc);
        else n_pass++;
        n_total++;
        if (MEM_o_wb_data !== 32'hFFFF_FF80) $display("FAIL lb_wb: got %h, want ffffff80", MEM_o_wb_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_store();
        int acc;
        issue(mk(32'h8000_0300, C_STORE, S_H, 32'h0000_1002, 32'hABCD_1234), 32'h0, 1'b1, acc);
        n_total++;
        if ({LSU_o_wstrb, LSU_o_wdata, LSU_o_wen, LSU_o_addr} !== {4'b1100, 32'h1234_1234, 1'b1, 32'h0000_1000})
            $display("FAIL sh_req: got wstrb=%b wdata=%h wen=%b addr=%h, want 1100 12341234 1 00001000",
                     LSU_o_wstrb, LSU_o_wdata, LSU_o_wen, LSU_o_addr);
        else n_pass++;
        LSU_i_req_ready = 1'b1;
        tick();
        LSU_i_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (MEM_o_valid !== 1'b0) $display("FAIL sh_wait_ack: got valid=%b in wait %0d, want 0", MEM_o_valid, i);
            else n_pass++;
            tick();
        end
        LSU_i_resp_valid = 1'b1;
        tick();
        LSU_i_resp_valid = 1'b0;
        n_total++;
        if (MEM_o_valid !== 1'b1) $display("FAIL sh_ack_valid: got %b, want 1", MEM_o_valid);
        else n_pass++;
        // Byte store to the top lane.
        issue(mk(32'h8000_0304, C_STORE, S_B, 32'h0000_2003, 32'h1111_22A5), 32'h0, 1'b1, acc);
        n_total++;
        if ({LSU_o_wstrb, LSU_o_wdata} !== {4'b1000, 32'hA5A5_A5A5})
            $display("FAIL sb_req: got wstrb=%b wdata=%h, want 1000 a5a5a5a5", LSU_o_wstrb, LSU_o_wdata);
        else n_pass++;
        mem_access(32'h0, 0, 1);
        tick();
    endtask

    task automatic test_backpressure();
        int acc;
        issue(mk(32'h8000_0400, C_STORE, S_W, 32'h0000_2000, 32'hDEAD_BEEF), 32'h0, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({LSU_o_req_valid, LSU_o_addr, LSU_o_wdata, LSU_o_wstrb, MEM_o_ready} !==
                {1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 1'b0})
                $display("FAIL stall_stable: cycle %0d got req=%b addr=%h wdata=%h wstrb=%b ready=%b, want 1 00002000 deadbeef 1111 0",
                         i, LSU_o_req_valid, LSU_o_addr, LSU_o_wdata, LSU_o_wstrb, MEM_o_ready);
            else n_pass++;
            tick();
        end
        mem_access(32'h0, 0, 0);
        tick();
    endtask

    task automatic test_load_variants();
        int acc;
        op_t         ops[6];
        logic [31:0] rd[6];
        ops[0] = mk(32'h8000_0500, C_LOAD, S_BU, 32'h0000_3001, 0); rd[0] = 32'h1234_F678;
        ops[1] = mk(32'h8000_0504, C_LOAD, S_H,  32'h0000_3002, 0); rd[1] = 32'h8001_0000;
        ops[2] = mk(32'h8000_0508, C_LOAD, S_HU, 32'h0000_3002, 0); rd[2] = 32'h8001_0000;
        ops[3] = mk(32'h8000_050C, C_LOAD, S_H,  32'h0000_3000, 0); rd[3] = 32'h0000_7FFF;
        ops[4] = mk(32'h8000_0510, C_LOAD, S_W,  32'h0000_3004, 0); rd[4] = 32'hDEAD_BEEF;
        ops[5] = mk(32'h8000_0514, C_LOAD, S_B,  32'h0000_3002, 0); rd[5] = 32'h007F_0000;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], rd[i], 1'b1, acc);
            mem_access(rd[i], i % 3, i % 2);
        end
        tick();
    endtask

    task automatic test_misaligned();
        int acc;
        bit seen_req;
        op_t ops[3];
        ops[0] = mk(32'h8000_0600, C_LOAD,  S_W,  32'h0000_4001, 0);
        ops[1] = mk(32'h8000_0604, C_LOAD,  S_HU, 32'h0000_4003, 0);
        ops[2] = mk(32'h8000_0608, C_STORE, S_H,  32'h0000_4001, 32'h5555_6666);
        for (int i = 0; i < 3; i++) begin
            seen_req = 1'b0;
            issue(ops[i], 32'h0, 1'b1, acc);
            n_total++;
            if ({MEM_o_valid, MEM_o_system_halt, MEM_o_wr} !== 4'b1100)
                $display("FAIL misaligned_%0d: got valid=%b halt=%b wr=%b, want 1 1 00",
                         i, MEM_o_valid, MEM_o_system_halt, MEM_o_wr);
            else n_pass++;
            for (int j = 0; j < 2; j++) begin
                if (LSU_o_req_valid !== 1'b0) seen_req = 1'b1;
                tick();
            end
            n_total++;
            if (seen_req) $display("FAIL misaligned_no_req_%0d: got req_valid=1, want never", i);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        int acc;
        MEM_i_ready = 1'b0;
        issue(mk(32'h8000_0700, C_ALU, S_W, 32'hCAFE_0001, 0), 32'h0, 1'b1, acc);
        // A competing op must not be taken while the result is stalled.
        MEM_i_valid = 1'b1;
        MEM_i_ALUout = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if ({MEM_o_valid, MEM_o_ready, MEM_o_wb_data, MEM_o_pc} !== {1'b1, 1'b0, 32'hCAFE_0001, 32'h8000_0700})
                $display("FAIL hold_stable: cycle %0d got valid=%b ready=%b wb=%h pc=%h, want 1 0 cafe0001 80000700",
                         i, MEM_o_valid, MEM_o_ready, MEM_o_wb_data, MEM_o_pc);
            else n_pass++;
            tick();
        end
        MEM_i_valid = 1'b0;
        MEM_i_ready = 1'b1;
        tick();
        n_total++;
        if (MEM_o_valid !== 1'b0) $display("FAIL hold_drain: got valid=%b, want 0", MEM_o_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        op_t o;
        for (int i = 0; i < 4; i++) begin
            o = mk(32'h8000_0800 + 32'(i * 4), (i == 2) ? 4'b1100 : C_ALU, S_W, 32'h1000 + 32'(i * 17), 0);
            MEM_i_valid = 1'b1;
            MEM_i_pc = o.pc; MEM_i_inst = o.inst; MEM_i_ALUout = o.alu; MEM_i_CSR_out = o.csr;
            MEM_i_rs2_data = o.rs2; MEM_i_rd = o.rd; MEM_i_csr_rd = o.csr_rd;
            MEM_i_ctrl = o.ctrl; MEM_i_size = o.size; MEM_i_system_halt = o.halt;
            #1;
            n_total++;
            if (MEM_o_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b, want 1", i, MEM_o_ready);
            else begin
                n_pass++;
                exp_q.push_back(model(o, 32'h0));
            end
            tick();
            n_total++;
            if ({MEM_o_valid, MEM_o_wb_data} !== {1'b1, o.alu})
                $display("FAIL b2b_out_%0d: got valid=%b wb=%h, want 1 %h", i, MEM_o_valid, MEM_o_wb_data, o.alu);
            else n_pass++;
        end
        MEM_i_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int acc;
        // Abort during RESP; a late response must be dropped.
        issue(mk(32'h8000_0900, C_LOAD, S_W, 32'h0000_5000, 0), 32'h0, 1'b0, acc);
        LSU_i_req_ready = 1'b1;
        tick();
        LSU_i_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        n_total++;
        if ({LSU_o_req_valid, MEM_o_valid} !== 2'b00)
            $display("FAIL rst_resp: got req=%b valid=%b, want 0 0", LSU_o_req_valid, MEM_o_valid);
        else n_pass++;
        rst = 1'b0;
        LSU_i_resp_valid = 1'b1;
        LSU_i_rdata = 32'h5555_AAAA;
        #1;
        n_total++;
        if (MEM_o_ready !== 1'b1) $display("FAIL rst_resp_idle: got ready=%b, want 1", MEM_o_ready);
        else n_pass++;
        tick();
        LSU_i_resp_valid = 1'b0;
        n_total++;
        if (MEM_o_valid !== 1'b0) $display("FAIL late_resp_ignored: got valid=%b, want 0", MEM_o_valid);
        else n_pass++;
        // Abort during REQ.
        issue(mk(32'h8000_0904, C_STORE, S_W, 32'h0000_5004, 32'h1), 32'h0, 1'b0, acc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({LSU_o_req_valid, MEM_o_valid} !== 2'b00)
            $display("FAIL rst_req: got req=%b valid=%b, want 0 0", LSU_o_req_valid, MEM_o_valid);
        else n_pass++;
        tick();
        // Recovery: a fresh ALU op completes normally.
        issue(mk(32'h8000_0908, C_ALU, S_W, 32'h0000_7777, 0), 32'h0, 1'b1, acc);
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_store();
        test_backpressure();
        test_load_variants();
        test_misaligned();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        tick(); tick();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending results, want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
